// File: rtl/da_serial_ctrl.sv
// Bit-serial sequencer for the distributed-arithmetic transform datapath.
// Accepts a frame of N_IN samples, issues one bit-plane per cycle (MSB first)
// to a single shared Decode unit, and shift-accumulates the returned partial
// sums into the full transform result.
module da_serial_ctrl #(
    parameter int N_IN      = 16,
    parameter int DW        = 8,
    parameter int PS_W      = 28,
    parameter int PS_LAT    = 1,
    parameter int SIGNED_IN = 1,
    parameter int ACC_W     = PS_W + DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN*DW-1:0]   in_data,
    output logic [N_IN-1:0]      slice,
    output logic                 slice_valid,
    input  logic [PS_W-1:0]      ps,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_data,
    output logic                 busy
);

    localparam int BCW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_reg;
    logic [BCW-1:0]     bcnt_reg;        // number of planes driven so far
    logic [PS_LAT-1:0]  en_pipe_reg;     // slice_valid delayed to ps arrival
    logic [PS_LAT-1:0]  msb_pipe_reg;    // tags the MSB plane
    logic [PS_LAT-1:0]  last_pipe_reg;   // tags the LSB (final) plane
    logic [ACC_W-1:0]   acc_reg;
    logic [ACC_W-1:0]   ps_ext;
    logic [ACC_W-1:0]   acc_next;
    logic [N_IN-1:0]    load_plane;      // MSB plane straight from in_data
    logic [N_IN-1:0]    shift_plane;     // next plane from the shift registers
    logic               accept;
    logic               acc_en;
    logic               acc_last;

    // Ready only when idle with no result pending; forced low while in reset.
    assign in_ready = rst_n & (state_reg == IDLE) & ~out_valid;
    assign accept   = in_valid & in_ready;
    assign busy     = (state_reg != IDLE);

    // Per-sample shift registers: the MSB is issued at the accept edge, so the
    // register holds the remaining bits left-aligned.
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_sample
        logic [DW-1:0] sample_reg;

        assign load_plane[gi]  = in_data[gi*DW + DW-1];
        assign shift_plane[gi] = sample_reg[DW-1];

        // Load on accept, shift left once per issued plane.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sample_reg <= '0;
            end else if (accept) begin
                sample_reg <= {in_data[gi*DW +: DW-1], 1'b0};
            end else if (state_reg == ISSUE) begin
                sample_reg <= {sample_reg[DW-2:0], 1'b0};
            end
        end
    end

    // Accumulate datapath: MSB plane seeds the accumulator (negated for
    // two's-complement inputs), later planes double-and-add.
    assign ps_ext   = {{(ACC_W-PS_W){ps[PS_W-1]}}, ps};
    assign acc_en   = en_pipe_reg[PS_LAT-1];
    assign acc_last = last_pipe_reg[PS_LAT-1];
    assign acc_next = msb_pipe_reg[PS_LAT-1]
                    ? ((SIGNED_IN != 0) ? (ACC_W'(0) - ps_ext) : ps_ext)
                    : ((acc_reg << 1) + ps_ext);

    // Enable pipeline: aligns each issued plane with its returning ps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_pipe_reg   <= '0;
            msb_pipe_reg  <= '0;
            last_pipe_reg <= '0;
        end else begin
            en_pipe_reg[0]   <= slice_valid;
            msb_pipe_reg[0]  <= slice_valid && (bcnt_reg == BCW'(1));
            last_pipe_reg[0] <= slice_valid && (bcnt_reg == BCW'(DW));
            for (int i = 1; i < PS_LAT; i++) begin
                en_pipe_reg[i]   <= en_pipe_reg[i-1];
                msb_pipe_reg[i]  <= msb_pipe_reg[i-1];
                last_pipe_reg[i] <= last_pipe_reg[i-1];
            end
        end
    end

    // Sequencer FSM with registered slice, accumulator and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            bcnt_reg    <= '0;
            slice       <= '0;
            slice_valid <= 1'b0;
            acc_reg     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (acc_en) begin
                acc_reg <= acc_next;
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        slice       <= load_plane;
                        slice_valid <= 1'b1;
                        bcnt_reg    <= BCW'(1);
                        state_reg   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bcnt_reg == BCW'(DW)) begin
                        slice       <= '0;
                        slice_valid <= 1'b0;
                        state_reg   <= DRAIN;
                    end else begin
                        slice    <= shift_plane;
                        bcnt_reg <= bcnt_reg + BCW'(1);
                    end
                end
                DRAIN: begin
                    if (acc_en && acc_last) begin
                        out_data  <= acc_next;
                        out_valid <= 1'b1;
                        bcnt_reg  <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_da_serial_ctrl.sv
// Scoreboard bench for da_serial_ctrl: a signed and an unsigned instance share
// stimulus, each driving its own registered Decode model.
module tb_da_serial_ctrl;
    localparam int N_IN  = 16;
    localparam int DW    = 8;
    localparam int PS_W  = 28;
    localparam int ACC_W = PS_W + DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [N_IN*DW-1:0] in_data = '0;

    logic s_in_ready, s_slice_valid, s_out_valid, s_busy;
    logic [N_IN-1:0] s_slice;
    logic [PS_W-1:0] s_ps;
    logic [ACC_W-1:0] s_out_data;
    logic u_in_ready, u_slice_valid, u_out_valid, u_busy;
    logic [N_IN-1:0] u_slice;
    logic [PS_W-1:0] u_ps;
    logic [ACC_W-1:0] u_out_data;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int last_acc_edge = 0;
    int last_xfer_edge = 0;
    int acc_edges[$];
    logic [ACC_W-1:0] exp_s_q[$];
    logic [ACC_W-1:0] exp_u_q[$];
    logic prev_ov = 1'b0;

    int coef [N_IN] = '{131072, 121094, 92681, 50159, 0, -50159, -92681, -121094,
                        -131072, -121094, -92681, -50159, 0, 50159, 92681, 121094};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    da_serial_ctrl #(.SIGNED_IN(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .slice(s_slice), .slice_valid(s_slice_valid), .ps(s_ps),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .busy(s_busy)
    );

    da_serial_ctrl #(.SIGNED_IN(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_data(in_data), .slice(u_slice), .slice_valid(u_slice_valid), .ps(u_ps),
        .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data), .busy(u_busy)
    );

    function automatic logic [PS_W-1:0] decode(input logic [N_IN-1:0] sl);
        int acc = 0;
        for (int j = 0; j < N_IN; j++) if (sl[j]) acc += coef[j];
        return PS_W'(acc);
    endfunction

    // Direct dot product of samples and coefficients, modulo 2^ACC_W.
    function automatic logic [ACC_W-1:0] model(input logic [N_IN*DW-1:0] d, input bit sgn);
        longint s = 0;
        longint xv;
        logic [DW-1:0] x;
        for (int j = 0; j < N_IN; j++) begin
            x  = d[j*DW +: DW];
            xv = sgn ? longint'(signed'(x)) : longint'(x);
            s += xv * longint'(coef[j]);
        end
        return ACC_W'(s);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Single-cycle Decode models.
    always @(posedge clk) begin
        s_ps <= decode(s_slice);
        u_ps <= decode(u_slice);
    end

    // Monitor: sampled mid-cycle; pushes on accept, pops on output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && s_in_ready) begin
                exp_s_q.push_back(model(in_data, 1'b1));
                exp_u_q.push_back(model(in_data, 1'b0));
                last_acc_edge = cyc + 1;
                acc_edges.push_back(cyc + 1);
                $display("accept  edge=%0d data=%h", cyc + 1, in_data);
            end
            if (s_out_valid && !prev_ov) chk("latency", 64'(cyc - last_acc_edge), 64'd9);
            if (s_out_valid && out_ready) begin
                last_xfer_edge = cyc + 1;
                if (exp_s_q.size() == 0) begin
                    chk("sb_empty", 64'd1, 64'd0);
                end else begin
                    logic [ACC_W-1:0] es, eu;
                    es = exp_s_q.pop_front();
                    eu = exp_u_q.pop_front();
                    $display("result  edge=%0d signed=%h unsigned=%h", cyc + 1, s_out_data, u_out_data);
                    chk("out_signed", 64'(s_out_data), 64'(es));
                    chk("u_out_valid", 64'(u_out_valid), 64'd1);
                    chk("out_unsigned", 64'(u_out_data), 64'(eu));
                end
            end
            prev_ov = s_out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    // Offer a frame and hold in_valid until it is accepted.
    task automatic send(input logic [N_IN*DW-1:0] d);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait until every pushed expectation has been compared.
    task automatic drain();
        int n = 0;
        while (exp_s_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                chk("drain_timeout", 64'(exp_s_q.size()), 64'd0);
                exp_s_q.delete();
                exp_u_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_IN*DW-1:0] rnd_frame();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_IN*DW-1:0] d;
        logic [ACC_W-1:0] hold;
        int n;

        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(s_in_ready), 64'd0);
        chk("rst_slice", 64'(s_slice), 64'd0);
        chk("rst_slice_valid", 64'(s_slice_valid), 64'd0);
        chk("rst_out_valid", 64'(s_out_valid), 64'd0);
        chk("rst_out_data", 64'(s_out_data), 64'd0);
        chk("rst_busy", 64'(s_busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 64'(s_in_ready), 64'd1);

        // Directed frames
        send('0);
        drain();
        d = '0; d[7:0] = 8'd1;
        send(d);
        drain();
        d = '0; d[15:8] = 8'd2;
        send(d);
        drain();
        d = '0; d[7:0] = 8'hFF;
        send(d);
        drain();
        chk("const_neg", 64'(s_out_data), 64'(36'hFFFFE0000));
        chk("const_uns", 64'(u_out_data), 64'd33423360);
        send(rnd_frame());
        drain();

        // Output backpressure
        out_ready = 1'b0;
        send(rnd_frame());
        n = 0;
        while (!s_out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_wait", 64'(s_out_valid), 64'd1);
        hold = s_out_data;
        in_data = rnd_frame();
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("bp_stable", 64'(s_out_data), 64'(hold));
            chk("bp_in_ready", 64'(s_in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accept_edge", 64'(last_acc_edge), 64'(last_xfer_edge + 1));
        drain();

        // Back-to-back
        acc_edges.delete();
        for (int i = 0; i < 4; i++) send(rnd_frame());
        drain();
        chk("b2b_count", 64'(acc_edges.size()), 64'd4);
        for (int i = 1; i < acc_edges.size(); i++)
            chk("b2b_period", 64'(acc_edges[i] - acc_edges[i-1]), 64'd11);

        // Reset mid-frame at plane 4
        send(rnd_frame());
        repeat (4) @(posedge clk);
        #2;
        chk("mid_slice_valid", 64'(s_slice_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_slice", 64'(s_slice), 64'd0);
        chk("mid_slice_valid0", 64'(s_slice_valid), 64'd0);
        chk("mid_out_valid", 64'(s_out_valid), 64'd0);
        chk("mid_out_data", 64'(s_out_data), 64'd0);
        chk("mid_busy", 64'(s_busy), 64'd0);
        chk("mid_in_ready", 64'(s_in_ready), 64'd0);
        exp_s_q.delete();
        exp_u_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(rnd_frame());
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
